mont_mul_ctrl: RTL and testbench

// Bit-serial Montgomery multiplier: result = in_a*in_b*2^-512 mod in_m.
// It is the initiator side of the adder start/done interface. It sequences

---
 rtl/mont_mul_ctrl_pkg.sv | 17 +
 rtl/mont_mul_ctrl_adder.sv | 55 +++++
 rtl/mont_mul_ctrl.sv | 126 ++++++++++++
 tb/tb_mont_mul_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mont_mul_ctrl_pkg.sv
// Shared widths and state encoding for the bit-serial Montgomery multiplier.
package mont_mul_ctrl_pkg;

  localparam int WIDTH   = 512;
  localparam int ADDER_W = 514;
  localparam int IDX_W   = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_B = 3'd1,
    ADD_M = 3'd2,
    SUB   = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mont_mul_ctrl_adder.sv
// 514-bit carry-select add/subtract with optional right shift; result registered,
// so operands presented in cycle t are visible in cycle t+1.
module adder
  import mont_mul_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               sub_i,
  input  logic               shift_i,
  input  logic [ADDER_W-1:0] a_i,
  input  logic [ADDER_W-1:0] b_i,
  output logic [ADDER_W:0]   res_o,
  output logic               done_o
);

  localparam int LO_W = ADDER_W / 2;
  localparam int HI_W = ADDER_W - LO_W;

  logic [ADDER_W-1:0] b_eff;
  logic [LO_W:0]      lo_sum;
  logic [HI_W:0]      hi_sum0;
  logic [HI_W:0]      hi_sum1;
  logic [HI_W:0]      hi_sel;
  logic [ADDER_W:0]   sum;
  logic [ADDER_W:0]   nxt;
  logic [ADDER_W:0]   res_q;
  logic               done_q;

  // Subtract is a + ~b + 1; the top result bit becomes the borrow flag.
  always_comb begin
    b_eff   = sub_i ? ~b_i : b_i;
    lo_sum  = {1'b0, a_i[LO_W-1:0]} + {1'b0, b_eff[LO_W-1:0]} + {{LO_W{1'b0}}, sub_i};
    hi_sum0 = {1'b0, a_i[ADDER_W-1:LO_W]} + {1'b0, b_eff[ADDER_W-1:LO_W]};
    hi_sum1 = {1'b0, a_i[ADDER_W-1:LO_W]} + {1'b0, b_eff[ADDER_W-1:LO_W]}
              + {{HI_W{1'b0}}, 1'b1};
    hi_sel  = lo_sum[LO_W] ? hi_sum1 : hi_sum0;
    sum     = {hi_sel[HI_W] ^ sub_i, hi_sel[HI_W-1:0], lo_sum[LO_W-1:0]};
    nxt     = shift_i ? {1'b0, sum[ADDER_W:1]} : sum;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= start_i;
      if (start_i) res_q <= nxt;
    end
  end

  assign res_o  = res_q;
  assign done_o = done_q;

endmodule

// File: rtl/mont_mul_ctrl.sv
// Bit-serial Montgomery multiplier controller: result = A*B*2^-512 mod M,
// driving one shared registered adder through alternating add-B / add-M-and-shift steps.
module mont_mul_ctrl
  import mont_mul_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, m_q, c_q, result_q;
  logic [IDX_W-1:0]   idx_q;
  logic               first_q;
  logic               done_q;

  logic               add_start, add_sub, add_shift, add_done;
  logic [ADDER_W-1:0] add_a, add_b;
  logic [ADDER_W:0]   add_res;

  always_comb begin
    add_start = 1'b0;
    add_sub   = 1'b0;
    add_shift = 1'b0;
    add_a     = '0;
    add_b     = '0;
    case (state_q)
      ADD_B: begin
        add_start = 1'b1;
        add_a     = first_q ? '0 : add_res[ADDER_W-1:0];
        add_b     = a_q[idx_q] ? {2'b00, b_q} : '0;
      end
      ADD_M: begin
        add_start = 1'b1;
        add_shift = 1'b1;
        add_a     = add_res[ADDER_W-1:0];
        add_b     = add_res[0] ? {2'b00, m_q} : '0;
      end
      SUB: begin
        add_start = 1'b1;
        add_sub   = 1'b1;
        add_a     = add_res[ADDER_W-1:0];
        add_b     = {2'b00, m_q};
      end
      default: ;
    endcase
  end

  adder u_adder (
    .clk_i   (clk),
    .rst_n_i (resetn),
    .start_i (add_start),
    .sub_i   (add_sub),
    .shift_i (add_shift),
    .a_i     (add_a),
    .b_i     (add_b),
    .res_o   (add_res),
    .done_o  (add_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            m_q     <= in_m;
            idx_q   <= '0;
            first_q <= 1'b1;
            state_q <= ADD_B;
          end
        end
        ADD_B: begin
          first_q <= 1'b0;
          state_q <= ADD_M;
        end
        ADD_M: begin
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_q <= SUB;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= ADD_B;
          end
        end
        SUB: begin
          c_q     <= add_res[WIDTH-1:0];
          state_q <= CMP;
        end
        CMP: begin
          result_q <= add_res[ADDER_W] ? c_q : add_res[WIDTH-1:0];
          state_q  <= DONE;
        end
        DONE: begin
          // done is registered one cycle after result lands; the pulse cycle ends DONE
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

  // The FSM relies on the fixed one-cycle adder latency; done is only cross-checked.
  assert property (@(posedge clk) disable iff (!resetn)
    add_done == ($past(add_start) && $past(resetn)));

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Directed and random checks of mont_mul_ctrl: exact vectors, abort, ignored starts,
// and back-to-back runs checked against the identity r*2^512 == A*B (mod M).
module tb_mont_mul_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [511:0] in_a, in_b, in_m;
  logic [511:0] result;
  logic         done;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] m;
    logic [511:0] exp;
  } vec_t;

  localparam int NVEC = 9;
  localparam int NRND = 24;

  vec_t         vecs [NVEC];
  logic [511:0] ra [NRND];
  logic [511:0] rb [NRND];
  logic [511:0] rm [NRND];

  mont_mul_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic mont_ok(input logic [511:0] a, input logic [511:0] b,
                                   input logic [511:0] m, input logic [511:0] r);
    logic [1023:0] mm, lhs, rhs;
    mm  = {512'b0, m};
    lhs = {r, 512'b0} % mm;
    rhs = ({512'b0, a} * {512'b0, b}) % mm;
    return (r < m) && (lhs == rhs);
  endfunction

  // One operation from a start pulse; scrambles inputs after the start edge and,
  // with poke set, re-asserts start at edges 10 and 600.
  task automatic run_op(input vec_t v, input bit poke, input string tag);
    int           first_done, n_done, bad_chg;
    logic [511:0] prev;
    first_done = -1;
    n_done     = 0;
    bad_chg    = 0;
    @(negedge clk);
    in_a  = v.a;
    in_b  = v.b;
    in_m  = v.m;
    start = 1'b1;
    prev  = result;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_a  = ~v.a;
    in_b  = ~v.b;
    in_m  = ~v.m;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (result !== prev && k != 1026) bad_chg++;
      prev  = result;
      start = poke && (k == 9 || k == 599);
      if (start) in_a = v.m - 512'd1;
    end
    start = 1'b0;
    chk_int({tag, "_done_edge"}, first_done, 1027);
    chk_int({tag, "_done_count"}, n_done, 1);
    chk512({tag, "_result"}, result, v.exp);
    chk_int({tag, "_result_hold"}, bad_chg, 0);
  endtask

  initial begin
    logic [511:0] m0, x0;
    int           n_done, k;

    m0 = {512{1'b1}} - 512'd568;
    x0 = {16{32'h1234_5678}};
    vecs[0] = '{512'd569,    512'd1,     m0,     512'd1};
    vecs[1] = '{512'd569,    x0,         m0,     x0};
    vecs[2] = '{512'd0,      m0 - 1,     m0,     512'd0};
    vecs[3] = '{512'd569,    m0 - 1,     m0,     m0 - 1};
    vecs[4] = '{512'd323761, 512'd1,     m0,     512'd569};
    vecs[5] = '{512'd2,      512'd569,   m0,     512'd2};
    vecs[6] = '{m0 - 1,      512'd569,   m0,     m0 - 1};
    vecs[7] = '{512'd1,      512'd2,     512'd3, 512'd2};
    vecs[8] = '{512'd2,      512'd2,     512'd3, 512'd1};

    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk512("reset_result", result, '0);
    chk_int("reset_done", int'(done), 0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Abort at cycle 500, then a clean run.
    @(negedge clk);
    in_a  = vecs[1].a;
    in_b  = vecs[1].b;
    in_m  = vecs[1].m;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk512("abort_result", result, '0);
    chk_int("abort_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n_done = 0;
    for (int j = 0; j < 700; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    chk_int("abort_no_done", n_done, 0);
    chk512("abort_result_idle", result, '0);
    run_op(vecs[1], 1'b0, "after_abort");

    run_op(vecs[0], 1'b1, "busy_start");

    // Back-to-back with start held high.
    for (int i = 0; i < NRND; i++) begin
      rm[i] = rand512() | {1'b1, 510'b0, 1'b1};
      ra[i] = rand512() % rm[i];
      rb[i] = rand512() % rm[i];
    end
    @(negedge clk);
    in_a  = ra[0];
    in_b  = rb[0];
    in_m  = rm[0];
    start = 1'b1;
    @(posedge clk);
    n_done = 0;
    k      = 0;
    while (n_done < NRND && k < NRND * 1029 + 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (done) begin
        chk_int($sformatf("rnd%0d_done_edge", n_done), k, 1027 + n_done * 1029);
        n_vec++;
        if (!mont_ok(ra[n_done], rb[n_done], rm[n_done], result)) begin
          n_fail++;
          $display("FAIL rnd%0d_result: got %h, not A*B*2^-512 mod %h",
                   n_done, result, rm[n_done]);
        end
        n_done++;
        if (n_done < NRND) begin
          in_a = ra[n_done];
          in_b = rb[n_done];
          in_m = rm[n_done];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk_int("rnd_done_total", n_done, NRND);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
